// File: rtl/bus_tenure_arbiter_if.sv
// Request/lock/grant bundle between the four bus masters and the tenure arbiter.
// All request, lock and grant lines are active-low; owner/bus_idle/preempt are status.
interface bus_tenure_arbiter_if;
  logic       m0_req_;
  logic       m1_req_;
  logic       m2_req_;
  logic       m3_req_;
  logic       m0_lock_;
  logic       m1_lock_;
  logic       m2_lock_;
  logic       m3_lock_;
  logic       m0_grnt_;
  logic       m1_grnt_;
  logic       m2_grnt_;
  logic       m3_grnt_;
  logic [1:0] owner;
  logic       bus_idle;
  logic       preempt;

  modport master (
    output m0_req_, m1_req_, m2_req_, m3_req_,
    output m0_lock_, m1_lock_, m2_lock_, m3_lock_,
    input  m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_,
    input  owner, bus_idle, preempt
  );

  modport slave (
    input  m0_req_, m1_req_, m2_req_, m3_req_,
    input  m0_lock_, m1_lock_, m2_lock_, m3_lock_,
    output m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_,
    output owner, bus_idle, preempt
  );
endinterface

// File: rtl/bus_tenure_arbiter.sv
// Four-master round-robin bus arbiter with bounded tenure, lock override and a
// one-cycle dead handoff between owners so two grants never overlap.
module bus_tenure_arbiter #(
  parameter int unsigned MAX_TENURE = 16,
  parameter int unsigned TENURE_W   = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  bus_tenure_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_HANDOFF = 2'd2
  } state_e;

  localparam logic [TENURE_W-1:0] TENURE_LAST = TENURE_W'(MAX_TENURE - 1);

  // Rotating priority: owner+1 first, the last owner itself last. Returns {found, index}.
  function automatic logic [2:0] pick_winner(input logic [3:0] req, input logic [1:0] last);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 4; i >= 1; i--) begin
      idx = last + 2'(i);
      if (req[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  state_e                state_q, state_d;
  logic [3:0]            grnt_q, grnt_d;
  logic [1:0]            owner_q, owner_d;
  logic [TENURE_W-1:0]   tenure_q, tenure_d;
  logic                  bus_idle_q, bus_idle_d;
  logic                  preempt_q, preempt_d;

  logic [3:0]            req_s;
  logic [3:0]            lock_s;
  logic [3:0]            owner_mask_s;
  logic [2:0]            win_s;
  logic                  contender_s;

  assign req_s        = ~{bus.m3_req_, bus.m2_req_, bus.m1_req_, bus.m0_req_};
  assign lock_s       = ~{bus.m3_lock_, bus.m2_lock_, bus.m1_lock_, bus.m0_lock_};
  assign owner_mask_s = 4'b0001 << owner_q;
  assign win_s        = pick_winner(req_s, owner_q);
  assign contender_s  = |(req_s & ~owner_mask_s);

  // Next-state, grant and status computation.
  always_comb begin
    state_d   = state_q;
    grnt_d    = grnt_q;
    owner_d   = owner_q;
    tenure_d  = tenure_q;
    preempt_d = 1'b0;
    case (state_q)
      ST_IDLE, ST_HANDOFF: begin
        if (win_s[2]) begin
          state_d  = ST_GRANT;
          owner_d  = win_s[1:0];
          tenure_d = '0;
          grnt_d   = ~(4'b0001 << win_s[1:0]);
        end else begin
          state_d  = ST_IDLE;
          grnt_d   = 4'hF;
        end
      end
      ST_GRANT: begin
        if (!req_s[owner_q]) begin
          // Release wins over the tenure limit: never a pre-empt here.
          grnt_d   = 4'hF;
          tenure_d = '0;
          if (contender_s) begin
            state_d = ST_HANDOFF;
          end else begin
            state_d = ST_IDLE;
          end
        end else if ((tenure_q == TENURE_LAST) && !lock_s[owner_q] && contender_s) begin
          state_d   = ST_HANDOFF;
          grnt_d    = 4'hF;
          tenure_d  = '0;
          preempt_d = 1'b1;
        end else begin
          state_d = ST_GRANT;
          if (tenure_q == TENURE_LAST) begin
            tenure_d = tenure_q;
          end else begin
            tenure_d = tenure_q + TENURE_W'(1);
          end
        end
      end
      default: begin
        state_d  = ST_IDLE;
        grnt_d   = 4'hF;
        tenure_d = '0;
      end
    endcase
    bus_idle_d = (state_d != ST_GRANT);
  end

  // State and output registers; reset drops every grant immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      grnt_q     <= 4'hF;
      owner_q    <= 2'd3;
      tenure_q   <= '0;
      bus_idle_q <= 1'b1;
      preempt_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grnt_q     <= grnt_d;
      owner_q    <= owner_d;
      tenure_q   <= tenure_d;
      bus_idle_q <= bus_idle_d;
      preempt_q  <= preempt_d;
    end
  end

  assign bus.m0_grnt_ = grnt_q[0];
  assign bus.m1_grnt_ = grnt_q[1];
  assign bus.m2_grnt_ = grnt_q[2];
  assign bus.m3_grnt_ = grnt_q[3];
  assign bus.owner    = owner_q;
  assign bus.bus_idle = bus_idle_q;
  assign bus.preempt  = preempt_q;

endmodule

// File: tb/tb_bus_tenure_arbiter.sv
// Directed bench for bus_tenure_arbiter: reset, rotation, handoff, tenure pre-emption,
// lock override, release-at-limit and mid-grant reset.
module tb_bus_tenure_arbiter;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [3:0] gnt;

  bus_tenure_arbiter_if bif();

  bus_tenure_arbiter #(.MAX_TENURE(16), .TENURE_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif.slave)
  );

  assign gnt = {bif.m3_grnt_, bif.m2_grnt_, bif.m1_grnt_, bif.m0_grnt_};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [3:0] g, input logic [1:0] own,
                             input logic idle, input logic pre);
    check({tag, "_gnt"},     {4'h0, gnt},           {4'h0, g});
    check({tag, "_owner"},   {6'h00, bif.owner},    {6'h00, own});
    check({tag, "_idle"},    {7'h00, bif.bus_idle}, {7'h00, idle});
    check({tag, "_preempt"}, {7'h00, bif.preempt},  {7'h00, pre});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bif.m0_req_ = 1'b1; bif.m1_req_ = 1'b1; bif.m2_req_ = 1'b1; bif.m3_req_ = 1'b1;
    bif.m0_lock_ = 1'b1; bif.m1_lock_ = 1'b1; bif.m2_lock_ = 1'b1; bif.m3_lock_ = 1'b1;
    #3;
    check_state("reset", 4'hF, 2'd3, 1'b1, 1'b0);
    #9;
    reset = 1'b0;
    step();
    check_state("idle_noreq", 4'hF, 2'd3, 1'b1, 1'b0);

    // T1: lone m2 request granted one cycle later
    bif.m2_req_ = 1'b0;
    step();
    check_state("t1_grant_m2", 4'b1011, 2'd2, 1'b0, 1'b0);
    bif.m2_req_ = 1'b1;
    step();
    check_state("t1_release_idle", 4'hF, 2'd2, 1'b1, 1'b0);

    // T2: m0 granted, releases with m1 and m3 waiting -> handoff then m1
    bif.m0_req_ = 1'b0;
    step();
    check_state("t2_grant_m0", 4'b1110, 2'd0, 1'b0, 1'b0);
    bif.m0_req_ = 1'b1; bif.m1_req_ = 1'b0; bif.m3_req_ = 1'b0;
    step();
    check_state("t2_handoff", 4'hF, 2'd0, 1'b1, 1'b0);
    step();
    check_state("t2_grant_m1", 4'b1101, 2'd1, 1'b0, 1'b0);

    // T3: m1 held 16 cycles while m2 waits, then pre-empted
    bif.m3_req_ = 1'b1; bif.m2_req_ = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      step();
      check("t3_m1_hold", {4'h0, gnt}, {4'h0, 4'b1101});
      check("t3_no_preempt", {7'h00, bif.preempt}, 8'h00);
    end
    step();
    check_state("t3_preempt", 4'hF, 2'd1, 1'b1, 1'b1);
    step();
    check_state("t3_grant_m2", 4'b1011, 2'd2, 1'b0, 1'b0);

    // T4: m2 releases to m1, which then locks and keeps the bus past the limit
    bif.m2_req_ = 1'b1;
    step();
    check_state("t4_handoff", 4'hF, 2'd2, 1'b1, 1'b0);
    bif.m1_lock_ = 1'b0; bif.m2_req_ = 1'b0;
    step();
    check_state("t4_grant_m1", 4'b1101, 2'd1, 1'b0, 1'b0);
    for (int i = 1; i <= 45; i++) begin
      step();
      check("t4_lock_hold", {4'h0, gnt}, {4'h0, 4'b1101});
      check("t4_lock_no_preempt", {7'h00, bif.preempt}, 8'h00);
    end
    bif.m1_lock_ = 1'b1;
    step();
    check_state("t4_unlock_preempt", 4'hF, 2'd1, 1'b1, 1'b1);
    step();
    check_state("t4_grant_m2", 4'b1011, 2'd2, 1'b0, 1'b0);

    // T5: m2 releases exactly at tenure 15 while m1 waits -> no pre-empt
    for (int i = 1; i <= 15; i++) begin
      step();
      check("t5_m2_hold", {4'h0, gnt}, {4'h0, 4'b1011});
    end
    bif.m2_req_ = 1'b1; bif.m3_req_ = 1'b0;
    step();
    check_state("t5_release_at_limit", 4'hF, 2'd2, 1'b1, 1'b0);
    step();
    check_state("t5_grant_m3", 4'b0111, 2'd3, 1'b0, 1'b0);
    bif.m3_req_ = 1'b1;
    step();
    check_state("t5_handoff2", 4'hF, 2'd3, 1'b1, 1'b0);
    step();
    check_state("t5_grant_m1", 4'b1101, 2'd1, 1'b0, 1'b0);

    // T6: reset mid-grant, then all requesting -> m0 first
    bif.m0_req_ = 1'b0; bif.m1_req_ = 1'b0; bif.m2_req_ = 1'b0; bif.m3_req_ = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_state("t6_async_reset", 4'hF, 2'd3, 1'b1, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    step();
    check_state("t6_grant_m0", 4'b1110, 2'd0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
